// File: rtl/seg_hex_disp.sv
// Multi-digit seven-segment hex display driver with per-digit decimal point,
// per-digit blink and optional leading-zero blanking. Segments are active-low.
module seg_hex_disp #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_NUM    = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lz_blank,
    output logic [8*NUM_DIGITS-1:0] o_seg,
    output logic                    blink_phase
);

    localparam int CW = (CLK_NUM > 2) ? $clog2(CLK_NUM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_NUM - 1);

    logic [CW-1:0]             count;
    logic                      loaded;
    logic [4*NUM_DIGITS-1:0]   sh_data;
    logic [NUM_DIGITS-1:0]     sh_dp;
    logic [NUM_DIGITS-1:0]     sh_blink;
    logic [8*NUM_DIGITS-1:0]   seg_next;

    // Active-high segment pattern, bit7=a .. bit1=g, bit0=dp (left clear)
    function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_pattern = 8'hFC;
            4'h1:    hex_pattern = 8'h60;
            4'h2:    hex_pattern = 8'hDA;
            4'h3:    hex_pattern = 8'hF2;
            4'h4:    hex_pattern = 8'h66;
            4'h5:    hex_pattern = 8'hB6;
            4'h6:    hex_pattern = 8'hBE;
            4'h7:    hex_pattern = 8'hE0;
            4'h8:    hex_pattern = 8'hFE;
            4'h9:    hex_pattern = 8'hF6;
            4'hA:    hex_pattern = 8'hEE;
            4'hB:    hex_pattern = 8'h3E;
            4'hC:    hex_pattern = 8'h9C;
            4'hD:    hex_pattern = 8'h7A;
            4'hE:    hex_pattern = 8'h9E;
            default: hex_pattern = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            blink_phase <= 1'b0;
        end else if (count == CNT_LAST) begin
            count       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded   <= 1'b0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
        end else if (load) begin
            loaded   <= 1'b1;
            sh_data  <= data;
            sh_dp    <= dp_en;
            sh_blink <= blink_en;
        end
    end

    // Walk from the most significant digit down; zero_run stays set while
    // this digit and every digit above it hold a zero nibble.
    always_comb begin : seg_decode
        logic       zero_run;
        logic [3:0] nib;
        seg_next = '1;
        zero_run = 1'b1;
        nib      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = sh_data[4*i +: 4];
            zero_run = zero_run & (nib == 4'h0);
            if (!loaded) begin
                seg_next[8*i +: 8] = 8'hFF;
            end else if (blink_phase && sh_blink[i]) begin
                seg_next[8*i +: 8] = 8'hFF;
            end else if (lz_blank && zero_run && (i != 0)) begin
                seg_next[8*i +: 8] = {7'h7F, ~sh_dp[i]};
            end else begin
                seg_next[8*i +: 8] = ~(hex_pattern(nib) | {7'b0, sh_dp[i]});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg <= '1;
        end else begin
            o_seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_hex_disp.sv
// Directed bench for seg_hex_disp with 4 digits and a 4-cycle blink half-period.
module tb_seg_hex_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic [3:0]  dp_en;
    logic [3:0]  blink_en;
    logic        lz_blank;
    logic [31:0] o_seg;
    logic        blink_phase;

    int n_vec = 0;
    int n_err = 0;
    int edges = 0;

    seg_hex_disp #(.NUM_DIGITS(4), .CLK_NUM(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .dp_en      (dp_en),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .o_seg      (o_seg),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Blink phase after e rising edges since reset release
    function automatic logic ph(input int e);
        return ((e / 4) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst   = 1'b0;
        edges = 0;
    endtask

    logic [7:0]  d0;
    logic        seen;

    initial begin
        rst      = 1'b1;
        data     = '0;
        load     = 1'b0;
        dp_en    = '0;
        blink_en = '0;
        lz_blank = 1'b0;
        #12;
        chk("rst_seg", o_seg, 32'hFFFF_FFFF);
        chk("rst_phase", {31'b0, blink_phase}, 32'h0);
        release_rst();

        // idle without load: dark, phase toggles every 4 edges
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_seg", o_seg, 32'hFFFF_FFFF);
            chk("idle_phase", {31'b0, blink_phase}, {31'b0, ph(edges)});
        end

        // plain load, two-edge latency
        data = 16'h12AF; load = 1'b1;
        tick();
        load = 1'b0;
        chk("lat_dark", o_seg, 32'hFFFF_FFFF);
        tick();
        chk("load_12af", o_seg, 32'h9F25_1171);

        // leading-zero blanking with dp on a blanked digit
        data = 16'h0005; dp_en = 4'b0100; lz_blank = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("lz_on", o_seg, 32'hFFFE_FF49);
        lz_blank = 1'b0;
        tick();
        chk("lz_off", o_seg, 32'h0302_0349);

        // single-digit blink
        data = 16'h8888; dp_en = '0; blink_en = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            d0 = ph(edges - 1) ? 8'hFF : 8'h01;
            chk("blink_seg", o_seg, {24'h010101, d0});
            chk("blink_phase", {31'b0, blink_phase}, {31'b0, ph(edges)});
        end

        // reset while digit 0 is dark
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (o_seg[7:0] == 8'hFF);
        end
        chk("wait_dark", {31'b0, seen}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_seg", o_seg, 32'hFFFF_FFFF);
        chk("mid_rst_phase", {31'b0, blink_phase}, 32'h0);
        @(posedge clk);
        release_rst();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_seg", o_seg, 32'hFFFF_FFFF);
            chk("post_rst_phase", {31'b0, blink_phase}, {31'b0, ph(edges)});
        end

        // load coinciding with the edge where the phase toggles
        for (int i = 0; i < 8 && ((edges + 1) % 4 != 0); i++) tick();
        chk("align", (edges + 1) % 4, 32'h0);
        data = 16'h3333; dp_en = '0; blink_en = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0;
        chk("sync_dark", o_seg, 32'hFFFF_FFFF);
        chk("sync_phase", {31'b0, blink_phase}, {31'b0, ph(edges)});
        for (int i = 0; i < 9; i++) begin
            tick();
            d0 = ph(edges - 1) ? 8'hFF : 8'h0D;
            chk("sync_seg", o_seg, {24'h0D0D0D, d0});
            chk("sync_period", {31'b0, blink_phase}, {31'b0, ph(edges)});
        end

        // back-to-back loads each shown for one cycle
        blink_en = '0; lz_blank = 1'b0;
        data = 16'h0123; load = 1'b1;
        tick();
        data = 16'h4567;
        tick();
        load = 1'b0;
        chk("b2b_first", o_seg, 32'h039F_250D);
        tick();
        chk("b2b_second", o_seg, 32'h9949_411F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
